// File: rtl/character_motion_if.sv
// Bundle of the frame-tick, button and collision inputs and the position/velocity/state
// outputs of the character motion engine.
interface character_motion_if #(
  parameter int POS_W = 8,
  parameter int VEL_W = 6
);
  logic                    enable;
  logic                    jump;
  logic                    move_left;
  logic                    move_right;
  logic                    left_blocked;
  logic                    right_blocked;
  logic                    up_blocked;
  logic                    down_blocked;
  logic [POS_W-1:0]        x_position;
  logic [POS_W-1:0]        y_position;
  logic signed [VEL_W-1:0] velocity;
  logic [1:0]              state;
  logic                    airborne;

  modport master (
    output enable, jump, move_left, move_right,
    output left_blocked, right_blocked, up_blocked, down_blocked,
    input  x_position, y_position, velocity, state, airborne
  );

  modport slave (
    input  enable, jump, move_left, move_right,
    input  left_blocked, right_blocked, up_blocked, down_blocked,
    output x_position, y_position, velocity, state, airborne
  );
endinterface

// File: rtl/character_motion.sv
// Per-frame motion engine for the player character: walk, jump and gravity, advancing
// only on enable ticks.
//   state      | meaning
//   GROUNDED 0 | standing on a surface, velocity 0, jump allowed on a button edge
//   RISING   1 | moving up after launch, gravity slows the ascent
//   FALLING  2 | moving down (or at apex), accelerating to terminal velocity
module character_motion #(
  parameter int POS_W      = 8,
  parameter int VEL_W      = 6,
  parameter int X_START    = 72,
  parameter int Y_START    = 0,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = (1 << POS_W) - 1,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 4,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  character_motion_if.slave    bus
);
  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;

  localparam logic [POS_W:0]          WALK_E   = WALK_SPEED[POS_W:0];
  localparam logic [POS_W:0]          XMIN_E   = X_MIN[POS_W:0];
  localparam logic [POS_W:0]          XMAX_E   = X_MAX[POS_W:0];
  localparam logic signed [VEL_W:0]   GRAV_E   = GRAVITY[VEL_W:0];
  localparam logic signed [VEL_W:0]   MAXF_E   = MAX_FALL[VEL_W:0];
  localparam logic signed [VEL_W-1:0] GRAV_V   = GRAVITY[VEL_W-1:0];
  localparam logic signed [VEL_W-1:0] MAXF_V   = MAX_FALL[VEL_W-1:0];
  localparam logic signed [VEL_W-1:0] LAUNCH_V = -JUMP_V[VEL_W-1:0];

  logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [1:0]              state_q, state_d;
  logic                    jump_prev_q, jump_prev_d;

  logic                    jump_edge, go_left, go_right;
  logic [POS_W:0]          x_ext, x_walk;
  logic signed [VEL_W:0]   v_grav;
  logic signed [VEL_W-1:0] v_rise, v_fall;

  // Position plus signed velocity, saturating at the screen edges instead of wrapping.
  function automatic logic [POS_W-1:0] y_add(input logic [POS_W-1:0] y,
                                             input logic signed [VEL_W-1:0] v);
    logic signed [POS_W+1:0] sum;
    sum = $signed({2'b00, y}) + $signed({{(POS_W+2-VEL_W){v[VEL_W-1]}}, v});
    if (sum[POS_W+1])    return '0;
    else if (sum[POS_W]) return '1;
    else                 return sum[POS_W-1:0];
  endfunction

  assign jump_edge = bus.jump & ~jump_prev_q;
  assign go_left   = bus.move_left & ~bus.move_right & ~bus.left_blocked;
  assign go_right  = bus.move_right & ~bus.move_left & ~bus.right_blocked;
  assign x_ext     = {1'b0, x_q};
  assign v_grav    = {vel_q[VEL_W-1], vel_q} + GRAV_E;
  assign v_rise    = v_grav[VEL_W-1:0];
  assign v_fall    = (v_grav > MAXF_E) ? MAXF_V : v_grav[VEL_W-1:0];

  always_comb begin
    x_walk = x_ext;
    if (go_left) begin
      if (x_ext < XMIN_E + WALK_E) x_walk = XMIN_E;
      else                         x_walk = x_ext - WALK_E;
    end else if (go_right) begin
      x_walk = x_ext + WALK_E;
      if (x_walk > XMAX_E) x_walk = XMAX_E;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q         <= X_START[POS_W-1:0];
      y_q         <= Y_START[POS_W-1:0];
      vel_q       <= '0;
      state_q     <= FALLING;
      jump_prev_q <= 1'b1;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      state_q     <= state_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vel_d       = vel_q;
    jump_prev_d = jump_prev_q;
    if (bus.enable) begin
      jump_prev_d = bus.jump;
      x_d         = x_walk[POS_W-1:0];
      case (state_q)
        GROUNDED: begin
          if (jump_edge && !bus.up_blocked) begin
            vel_d   = LAUNCH_V;
            state_d = RISING;
          end else if (!bus.down_blocked) begin
            vel_d   = GRAV_V;
            y_d     = y_add(y_q, GRAV_V);
            state_d = FALLING;
          end
        end
        RISING: begin
          if (bus.up_blocked) begin
            vel_d   = '0;
            state_d = FALLING;
          end else begin
            vel_d = v_rise;
            y_d   = y_add(y_q, v_rise);
            if (!v_rise[VEL_W-1]) state_d = FALLING;
          end
        end
        FALLING: begin
          if (bus.down_blocked) begin
            vel_d   = '0;
            state_d = GROUNDED;
          end else begin
            vel_d = v_fall;
            y_d   = y_add(y_q, v_fall);
          end
        end
        default: begin
          vel_d   = '0;
          state_d = FALLING;
        end
      endcase
    end
  end

  always_comb begin
    bus.x_position = x_q;
    bus.y_position = y_q;
    bus.velocity   = vel_q;
    bus.state      = state_q;
    bus.airborne   = (state_q != GROUNDED);
  end
endmodule

// File: tb/tb_character_motion.sv
// Directed physics scenarios followed by randomized ticks, all checked against a
// behavioural model of the motion rules.
module tb_character_motion;
  localparam int POS_W = 8;
  localparam int VEL_W = 6;
  localparam int XS = 72, YS = 0, XMN = 0, XMX = 255, WALK = 2, JV = 4, GR = 1, MF = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  character_motion_if #(.POS_W(POS_W), .VEL_W(VEL_W)) bus ();
  character_motion #(.POS_W(POS_W), .VEL_W(VEL_W)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_x, m_y, m_v, m_st;
  bit m_jp;

  int fall_y[10] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
  int fall_v[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
  int jump_y[6]  = '{97, 95, 94, 94, 95, 97};

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_x"}, bus.x_position, m_x);
    chk({tag, "_y"}, bus.y_position, m_y);
    chk({tag, "_vel"}, bus.velocity, m_v);
    chk({tag, "_state"}, bus.state, m_st);
    chk({tag, "_airborne"}, bus.airborne, (m_st != 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_x = XS; m_y = YS; m_v = 0; m_st = 2; m_jp = 1'b1;
  endtask

  task automatic model_step(input bit j, ml, mr, lb, rb, ub, db);
    bit jedge;
    jedge = j && !m_jp;
    if (ml && !mr && !lb)      m_x = (m_x - WALK < XMN) ? XMN : m_x - WALK;
    else if (mr && !ml && !rb) m_x = (m_x + WALK > XMX) ? XMX : m_x + WALK;
    if (m_st == 0) begin
      if (jedge && !ub) begin m_v = -JV; m_st = 1; end
      else if (!db) begin m_v = GR; m_y = m_y + GR; m_st = 2; end
    end else if (m_st == 1) begin
      if (ub) begin m_v = 0; m_st = 2; end
      else begin
        m_v = m_v + GR;
        m_y = m_y + m_v;
        if (m_v >= 0) m_st = 2;
      end
    end else begin
      if (db) begin m_v = 0; m_st = 0; end
      else begin
        m_v = (m_v + GR > MF) ? MF : m_v + GR;
        m_y = m_y + m_v;
      end
    end
    if (m_y < 0)   m_y = 0;
    if (m_y > 255) m_y = 255;
    m_jp = j;
  endtask

  task automatic tick(input bit en, j, ml, mr, lb, rb, ub, db);
    bus.enable = en; bus.jump = j; bus.move_left = ml; bus.move_right = mr;
    bus.left_blocked = lb; bus.right_blocked = rb; bus.up_blocked = ub; bus.down_blocked = db;
    @(posedge clock);
    if (en) model_step(j, ml, mr, lb, rb, ub, db);
    #1;
    check_all("tick");
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clock);
    #1;
    check_all("rst_held");
    resetn = 1'b1;
  endtask

  initial begin
    bus.enable = 0; bus.jump = 0; bus.move_left = 0; bus.move_right = 0;
    bus.left_blocked = 0; bus.right_blocked = 0; bus.up_blocked = 0; bus.down_blocked = 0;
    #1 resetn = 1'b0;
    #2;
    chk("reset_x", bus.x_position, 72);
    chk("reset_y", bus.y_position, 0);
    chk("reset_vel", bus.velocity, 0);
    chk("reset_state", bus.state, 2);
    chk("reset_airborne", bus.airborne, 1);
    model_reset();
    #9 resetn = 1'b1;

    // Free fall from the top towards a floor at y=100.
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fall_y", bus.y_position, fall_y[i]);
      chk("fall_vel", bus.velocity, fall_v[i]);
    end
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, 0, 0, 0);
    chk("floor_y", bus.y_position, 100);
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    chk("land_state", bus.state, 0);
    chk("land_vel", bus.velocity, 0);

    // Single jump pulse.
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    chk("launch_state", bus.state, 1);
    chk("launch_vel", bus.velocity, -4);
    chk("launch_y", bus.y_position, 100);
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("jump_y", bus.y_position, jump_y[i]);
      if (i == 3) chk("apex_state", bus.state, 2);
    end
    tick(1, 0, 0, 0, 0, 0, 0, 1);

    // Jump held through the whole arc and the landing.
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0, 0, 1);
    chk("no_relaunch", bus.state, 0);

    // Head bump on the second airborne tick.
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0);
    chk("bump_vel", bus.velocity, 0);
    chk("bump_state", bus.state, 2);
    tick(1, 0, 0, 0, 0, 0, 0, 1);

    // Walking and horizontal clamp.
    do_reset();
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      tick(1, 0, 0, 1, 0, 0, 0, 1);
      if (i == 90) chk("walk_254", bus.x_position, 254);
    end
    chk("walk_clamp", bus.x_position, 255);
    tick(1, 0, 1, 1, 0, 0, 0, 1);
    chk("walk_both", bus.x_position, 255);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 1, 0, 1, 0, 1);
    chk("walk_blocked", bus.x_position, 245);
    tick(1, 0, 1, 0, 1, 0, 0, 1);
    chk("walk_lblocked", bus.x_position, 245);

    // Launch from near the top edge: y must clamp at 0.
    do_reset();
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    chk("top_clamp", bus.y_position, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    chk("top_clamp2", bus.y_position, 0);

    // Async reset mid-fall while enable is low.
    for (int i = 0; i < 12; i++) tick(1, 0, 0, 0, 0, 0, 0, 0);
    bus.enable = 0;
    #2 resetn = 1'b0;
    #1;
    chk("areset_x", bus.x_position, 72);
    chk("areset_y", bus.y_position, 0);
    chk("areset_vel", bus.velocity, 0);
    chk("areset_state", bus.state, 2);
    model_reset();
    @(posedge clock);
    #3 resetn = 1'b1;

    // enable low holds everything regardless of other inputs.
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));

    // Randomized ticks.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/character_motion.md
# character_motion

Parametrised per-frame motion engine for the player character: it holds the character's on-screen X/Y position and a signed vertical velocity, and applies walk, jump and gravity using a three-state jump FSM. It sits between the input/collision logic (`*_blocked` flags from the tile collision checker) and the sprite renderer, which consumes `x_position`/`y_position`. All physics advance once per `enable` (frame tick) pulse; between ticks every register holds.

## Interface
Parameters:
- `POS_W`, 8: width of `x_position`/`y_position` (unsigned pixels).
- `VEL_W`, 6: width of signed vertical velocity (two's complement).
- `X_START`, 72: `x_position` after reset.
- `Y_START`, 0: `y_position` after reset.
- `X_MIN`, 0 / `X_MAX`, 2^POS_W-1: horizontal clamp limits.
- `WALK_SPEED`, 2: pixels moved per tick when walking.
- `JUMP_V`, 4: launch speed; velocity is set to −JUMP_V.
- `GRAVITY`, 1: velocity increment per tick while airborne.
- `MAX_FALL`, 8: terminal downward velocity. Constraint: JUMP_V, MAX_FALL ≤ 2^(VEL_W-1)-1.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  frame tick. State updates only on cycles with enable=1.
- `jump`  in  1  jump button, level.
- `move_left`, `move_right`  in  1 each  walk buttons, level.
- `left_blocked`, `right_blocked`, `up_blocked`, `down_blocked`  in  1 each  collision flags for the current position.
- `x_position`, `y_position`  out  POS_W  registered position.
- `velocity`  out  VEL_W  registered signed vertical velocity (negative = up).
- `state`  out  2  FSM state: GROUNDED=0, RISING=1, FALLING=2. Value 3 is unreachable and recovers to FALLING.
- `airborne`  out  1  1 when state≠GROUNDED.

## Operation
- Reset (async, resetn=0): x=X_START, y=Y_START, velocity=0, state=FALLING, jump history=1. The history value of 1 blocks an immediate jump if the button is held through reset.
- Jump edge: `jump_edge = jump & ~jump_prev`. `jump_prev` updates only on enable cycles, so a jump is taken only on a rising edge sampled at tick granularity. Holding jump does not auto-repeat.
- Horizontal, evaluated in every state on a tick:
  - move_left & ~move_right & ~left_blocked: x -= WALK_SPEED.
  - move_right & ~move_left & ~right_blocked: x += WALK_SPEED.
  - Otherwise x holds.
  - Result is clamped to [X_MIN, X_MAX] using POS_W+1-bit arithmetic, so x never wraps.
- GROUNDED (velocity=0):
  - jump_edge & ~up_blocked: velocity=−JUMP_V, go to RISING, y unchanged this tick.
  - Else ~down_blocked: velocity=GRAVITY, y+=GRAVITY, go to FALLING. This covers walking off a ledge.
  - Else hold.
- RISING:
  - up_blocked: velocity=0, y holds, go to FALLING (head bump).
  - Else v' = velocity+GRAVITY and y += v' (signed). If v' ≥ 0, go to FALLING.
- FALLING:
  - down_blocked: velocity=0, y holds, go to GROUNDED.
  - Else v' = min(velocity+GRAVITY, MAX_FALL) and y += v'.
  - jump is ignored; there is no double jump.
- Y arithmetic: signed add in POS_W+1 bits, saturating at 0 and 2^POS_W-1. No wrap-around.
- Simultaneous up_blocked & down_blocked: in RISING, the head bump wins. In FALLING, landing wins. In GROUNDED, no jump is taken (up_blocked) and the character stays grounded.

## Timing
- All outputs are registered. Effects of a tick appear on the clock edge that samples enable=1, i.e. visible one cycle after that tick cycle.
- Inputs are sampled only on enable cycles. enable=0 holds x, y, velocity, state and jump_prev.
- Reset asserted mid-jump clears everything immediately and asynchronously. Release is synchronous in effect: the first tick after release is evaluated from the reset values.
- Latency from jump edge on a tick to `state`=RISING: 1 cycle.

## Test plan
- Reset, then floor: hold down_blocked=0 with Y_START=0 for 10 ticks.
  - velocity runs 1,2,…,8,8,8.
  - y reaches 1,3,6,10,15,21,28,36,44,52.
  - Then down_blocked=1 gives state GROUNDED and velocity 0.
- Full jump with defaults, grounded at y=100, down_blocked drops to 0 after launch, single jump pulse:
  - y runs 100, 97, 95, 94, 94. State goes FALLING at the tick where v'=0.
  - Next ticks give y=95, 97.
  - Holding jump through landing must not relaunch.
- Head bump: up_blocked=1 on the second airborne tick → velocity=0, state FALLING, y unchanged that tick.
- Walk:
  - move_right for 100 ticks from x=72 with X_MAX=255: x saturates at 254, then 255 (clamp). It never wraps.
  - move_left & move_right both high: x holds.
  - right_blocked=1: x holds.
- Saturation at the top: Y_START=2, launch jump → y clamps at 0, with no wrap to 255.
- Async reset mid-fall with enable=0: outputs go to reset values within the same cycle, without waiting for a clock edge. enable=0 alone holds all registers for 20 cycles.
